cheat_loader: RTL and testbench

Sequencer between the HPS cheat-file download path and the cheat code engine. It clears the engine at the start of a download and assembles the 16-bit download stream into 128-bit code records. Each record is presented to the engine with a timed clock-bit strobe, and the download is back-pressured while the engine is being written. It also drives the engine's enable so that cheats are live only when a load is complete and the user has them switched on.

---
 rtl/cheat_loader.sv | 177 +++++++++++++++++
 tb/tb_cheat_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheat_loader.sv
// rtl/cheat_loader.sv - packs 16-bit cheat download words into 128-bit engine records with timed clock-bit strobes
module cheat_loader #(
    parameter int MAX_CODES    = 32,
    parameter int STROBE_HOLD  = 4,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           dl_start,
    input  logic                           dl_wr,
    input  logic [15:0]                    dl_data,
    input  logic                           dl_done,
    output logic                           dl_wait,
    input  logic                           user_enable,
    output logic [128:0]                   code_out,
    output logic                           codes_clear,
    output logic                           cheats_active,
    output logic [$clog2(MAX_CODES+1)-1:0] loaded_count,
    output logic                           overflow
);

    localparam int CW   = $clog2(MAX_CODES + 1);
    localparam int TMAX = (STROBE_HOLD > CLEAR_CYCLES) ? STROBE_HOLD : CLEAR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLEAR     = 3'd1;
    localparam logic [2:0] S_COLLECT   = 3'd2;
    localparam logic [2:0] S_STROBE_HI = 3'd3;
    localparam logic [2:0] S_STROBE_LO = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [2:0]    word_cnt_q, word_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          done_pend_q, done_pend_d;
    logic [128:0]  code_q, code_d;
    logic          clear_q, clear_d;
    logic          wait_q, wait_d;
    logic          active_q, active_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          go_strobe;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        tmr_d       = tmr_q;
        done_pend_d = done_pend_q;
        code_d      = code_q;
        clear_d     = clear_q;
        wait_d      = wait_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        go_strobe   = 1'b0;
        active_d    = user_enable && (state_q == S_IDLE) && (count_q != '0);

        case (state_q)
            S_IDLE: begin
                wait_d = 1'b0;
            end
            S_CLEAR: begin
                if (tmr_q == TW'(CLEAR_CYCLES - 1)) begin
                    state_d = S_COLLECT;
                    clear_d = 1'b0;
                    wait_d  = 1'b0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_COLLECT: begin
                wait_d = 1'b0;
                if (dl_wr) begin
                    // File bytes arrive little-end first; swap so fields land big-endian.
                    for (int i = 0; i < 8; i++) begin
                        if (word_cnt_q == 3'(i)) begin
                            code_d[127-16*i -: 16] = {dl_data[7:0], dl_data[15:8]};
                        end
                    end
                    word_cnt_d = word_cnt_q + 3'd1;
                    if (word_cnt_q == 3'd7) begin
                        if (count_q < CW'(MAX_CODES)) begin
                            go_strobe = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                if (go_strobe) begin
                    state_d     = S_STROBE_HI;
                    code_d[128] = 1'b1;
                    wait_d      = 1'b1;
                    tmr_d       = '0;
                    done_pend_d = dl_done;
                end else if (dl_done) begin
                    state_d    = S_IDLE;
                    word_cnt_d = 3'd0;
                end
            end
            S_STROBE_HI: begin
                done_pend_d = done_pend_q | dl_done;
                if (tmr_q == TW'(STROBE_HOLD - 1)) begin
                    state_d     = S_STROBE_LO;
                    code_d[128] = 1'b0;
                    tmr_d       = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_STROBE_LO: begin
                done_pend_d = done_pend_q | dl_done;
                if (tmr_q == TW'(STROBE_HOLD - 1)) begin
                    if (count_q != CW'(MAX_CODES)) begin
                        count_d = count_q + 1'b1;
                    end
                    wait_d      = 1'b0;
                    tmr_d       = '0;
                    done_pend_d = 1'b0;
                    state_d     = (done_pend_q || dl_done) ? S_IDLE : S_COLLECT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new download pre-empts everything, including an in-flight strobe.
        if (dl_start) begin
            state_d     = S_CLEAR;
            clear_d     = 1'b1;
            wait_d      = 1'b1;
            tmr_d       = '0;
            word_cnt_d  = 3'd0;
            count_d     = '0;
            ovf_d       = 1'b0;
            code_d      = '0;
            done_pend_d = 1'b0;
            active_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= 3'd0;
            tmr_q       <= '0;
            done_pend_q <= 1'b0;
            code_q      <= '0;
            clear_q     <= 1'b0;
            wait_q      <= 1'b0;
            active_q    <= 1'b0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            tmr_q       <= tmr_d;
            done_pend_q <= done_pend_d;
            code_q      <= code_d;
            clear_q     <= clear_d;
            wait_q      <= wait_d;
            active_q    <= active_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    assign code_out      = code_q;
    assign codes_clear   = clear_q;
    assign dl_wait       = wait_q;
    assign cheats_active = active_q;
    assign loaded_count  = count_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_cheat_loader.sv
// tb/tb_cheat_loader.sv - randomized self-checking bench for cheat_loader against a byte-stream record model
module tb_cheat_loader;

    localparam int MAXC = 32;
    localparam int SH   = 4;
    localparam int CC   = 2;
    localparam int CW   = $clog2(MAXC + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          dl_start, dl_wr, dl_done, user_enable;
    logic [15:0]   dl_data;
    logic          dl_wait, codes_clear, cheats_active, overflow;
    logic [128:0]  code_out;
    logic [CW-1:0] loaded_count;

    always #5 clk = ~clk;

    cheat_loader #(.MAX_CODES(MAXC), .STROBE_HOLD(SH), .CLEAR_CYCLES(CC)) dut (
        .clk(clk), .reset_n(reset_n), .dl_start(dl_start), .dl_wr(dl_wr),
        .dl_data(dl_data), .dl_done(dl_done), .dl_wait(dl_wait),
        .user_enable(user_enable), .code_out(code_out), .codes_clear(codes_clear),
        .cheats_active(cheats_active), .loaded_count(loaded_count), .overflow(overflow)
    );

    int errors = 0;
    int checks = 0;

    logic [127:0] seen[$];
    logic [127:0] expq[$];
    logic         prev_strobe = 1'b0;

    int           m_count;
    bit           m_ovf;
    logic [7:0]   m_bytes[$];

    always @(negedge clk) begin
        if (code_out[128] && !prev_strobe) seen.push_back(code_out[127:0]);
        prev_strobe <= code_out[128];
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (dl_wait && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (dl_wait) chk("wait_ready_timeout", 1, 0);
    endtask

    task automatic model_reset();
        m_count = 0;
        m_ovf   = 0;
        m_bytes.delete();
    endtask

    task automatic start_dl(output int nclr);
        dl_start = 1'b1;
        @(negedge clk);
        dl_start = 1'b0;
        nclr = 0;
        while (codes_clear && nclr < 20) begin
            nclr++;
            @(negedge clk);
        end
        model_reset();
    endtask

    task automatic send_word(input logic [15:0] d, input bit with_done);
        logic [127:0] rec;
        wait_ready();
        dl_wr   = 1'b1;
        dl_data = d;
        dl_done = with_done;
        @(negedge clk);
        dl_wr   = 1'b0;
        dl_done = 1'b0;
        dl_data = 16'($urandom);
        m_bytes.push_back(d[7:0]);
        m_bytes.push_back(d[15:8]);
        if (m_bytes.size() == 16) begin
            rec = '0;
            foreach (m_bytes[i]) rec = (rec << 8) | 128'(m_bytes[i]);
            if (m_count < MAXC) begin
                expq.push_back(rec);
                m_count++;
            end else begin
                m_ovf = 1;
            end
            m_bytes.delete();
        end
        if (with_done) m_bytes.delete();
    endtask

    task automatic send_done();
        wait_ready();
        dl_done = 1'b1;
        @(negedge clk);
        dl_done = 1'b0;
        m_bytes.delete();
    endtask

    task automatic settle();
        wait_ready();
        tick(3);
    endtask

    task automatic send_records(input int nrec, input bit done_last);
        for (int r = 0; r < nrec; r++)
            for (int w = 0; w < 8; w++) begin
                tick($urandom_range(0, 2));
                send_word(16'($urandom), done_last && (r == nrec - 1) && (w == 7));
            end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "/loaded_count"}, 128'(loaded_count), 128'(m_count));
        chk({tag, "/overflow"}, 128'(overflow), 128'(m_ovf));
        chk({tag, "/cheats_active"}, 128'(cheats_active), 128'(user_enable && m_count != 0));
        chk({tag, "/strobes"}, 128'(seen.size()), 128'(expq.size()));
    endtask

    initial begin
        int nclr, busy, hi, base;
        logic [15:0] top;

        reset_n = 1'b0; dl_start = 0; dl_wr = 0; dl_done = 0; dl_data = '0; user_enable = 0;
        model_reset();
        tick(3);
        chk("reset/code_out", 128'(code_out), 0);
        chk("reset/code_bit", 128'(code_out[128]), 0);
        chk("reset/misc", 128'({codes_clear, dl_wait, cheats_active, overflow}), 0);
        chk("reset/loaded_count", 128'(loaded_count), 0);
        reset_n = 1'b1;
        tick(2);

        // Directed record: bytes 00..0f in file order.
        start_dl(nclr);
        chk("directed/clear_cycles", 128'(nclr), 128'(CC));
        for (int i = 0; i < 8; i++) send_word({8'(2*i+1), 8'(2*i)}, 0);
        top = code_out[127:112];
        chk("directed/top_word", 128'(top), 128'h0001);
        busy = 0; hi = 0;
        while (dl_wait && busy < 64) begin
            if (code_out[128]) hi++;
            busy++;
            @(negedge clk);
        end
        chk("directed/busy_cycles", 128'(busy), 128'(2*SH));
        chk("directed/strobe_high", 128'(hi), 128'(SH));
        chk("directed/count_after_strobe", 128'(loaded_count), 1);
        send_done();
        user_enable = 1'b1;
        settle();
        check_state("directed");
        chk("directed/record", seen[seen.size()-1], 128'h000102030405060708090a0b0c0d0e0f);

        // Partial record is discarded, then a fresh load strobes once.
        start_dl(nclr);
        for (int i = 0; i < 5; i++) send_word(16'($urandom), 0);
        send_done();
        settle();
        check_state("partial");
        base = seen.size();
        start_dl(nclr);
        send_records(1, 0);
        send_done();
        settle();
        check_state("after_partial");
        chk("after_partial/one_strobe", 128'(seen.size() - base), 1);

        // dl_done on the same cycle as the 8th word.
        start_dl(nclr);
        send_records(1, 1);
        settle();
        check_state("done_on_last");

        // One record past capacity.
        start_dl(nclr);
        send_records(MAXC + 1, 0);
        send_done();
        settle();
        check_state("overflow");

        for (int it = 0; it < 6; it++) begin
            int  nrec;
            bit  part, dlast;
            user_enable = 1'($urandom);
            nrec  = $urandom_range(0, 6);
            part  = 1'($urandom);
            dlast = (nrec > 0) && !part && 1'($urandom);
            start_dl(nclr);
            chk($sformatf("rand%0d/clear_cycles", it), 128'(nclr), 128'(CC));
            send_records(nrec, dlast);
            if (part) for (int i = 0; i < $urandom_range(1, 7); i++) send_word(16'($urandom), 0);
            if (!dlast) send_done();
            settle();
            check_state($sformatf("rand%0d", it));
        end

        // dl_start while the strobe is in its low phase.
        user_enable = 1'b1;
        start_dl(nclr);
        send_records(1, 0);
        tick(SH + 1);
        dl_start = 1'b1;
        @(negedge clk);
        dl_start = 1'b0;
        chk("abort/code_bit", 128'(code_out[128]), 0);
        chk("abort/codes_clear", 128'(codes_clear), 1);
        chk("abort/loaded_count", 128'(loaded_count), 0);
        model_reset();
        nclr = 0;
        while (codes_clear && nclr < 20) begin nclr++; @(negedge clk); end
        send_done();
        settle();
        check_state("abort");

        // Reset asserted during the high phase of a strobe.
        start_dl(nclr);
        send_records(1, 0);
        tick(1);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset/code_out", 128'(code_out), 0);
        chk("midreset/code_bit", 128'(code_out[128]), 0);
        chk("midreset/misc", 128'({codes_clear, dl_wait, cheats_active, overflow}), 0);
        chk("midreset/loaded_count", 128'(loaded_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        tick(4);
        chk("midreset/cheats_after", 128'(cheats_active), 0);
        base = seen.size();
        dl_wr = 1'b1;
        tick(10);
        dl_wr = 1'b0;
        tick(2);
        chk("idle/ignores_wr", 128'(seen.size() - base), 0);
        check_state("idle");

        chk("final/strobes", 128'(seen.size()), 128'(expq.size()));
        for (int i = 0; i < seen.size() && i < expq.size(); i++)
            chk($sformatf("record%0d", i), seen[i], expq[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
